// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

  localparam int MA_ADDR_W = 16;
  localparam int MA_DATA_W = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [MA_ADDR_W-1:0] addr;
    logic [MA_DATA_W-1:0] wdata;
  } slot_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// rtl/mem_arb_slot.sv - one-entry request buffer holding a port's pending memory request
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req,
  input  slot_t din,
  input  logic  clr,
  output logic  pend,
  output slot_t dout
);

  // Capture only into an empty slot; a request against a full slot is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (req && !pend) begin
      pend <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with refill lock; ARB_STATS_EN adds grant/conflict counters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = MA_ADDR_W,
  parameter int DATA_W    = MA_DATA_W,
  parameter int BURST_LEN = 8,
  parameter int OFFSET_W  = 5,
  parameter int LOCK_TMO  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             p_req,
  input  logic [1:0]             p_we,
  input  logic [1:0][ADDR_W-1:0] p_addr,
  input  logic [1:0][DATA_W-1:0] p_wdata,
  output logic [1:0]             p_ready,
  output logic [1:0]             p_done,
  output logic [DATA_W-1:0]      p_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic                   mem_done,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [15:0]            st_grant0,
  output logic [15:0]            st_grant1,
  output logic [15:0]            st_conflict
);

  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam int TMO_W = $clog2(LOCK_TMO + 1);

  state_t              state, state_nx;
  logic [1:0]          pend, clr;
  slot_t               slot_in [2];
  slot_t               slot_q  [2];
  slot_t               sel_slot;
  logic                sel, sel_vld, issue;
  logic                owner, last_grant;
  logic                lock, lock_port;
  logic [BC_W-1:0]     burst_cnt;
  logic [TMO_W-1:0]    idle_cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign slot_in[g] = '{we: p_we[g], addr: p_addr[g], wdata: p_wdata[g]};
    mem_arb_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .req  (p_req[g]),
      .din  (slot_in[g]),
      .clr  (clr[g]),
      .pend (pend[g]),
      .dout (slot_q[g])
    );
  end

  assign p_ready = ~pend;

  // Choose the candidate slot: lock owner only while locked, else round-robin on contention.
  always_comb begin
    sel     = PORT_I;
    sel_vld = 1'b0;
    if (lock) begin
      sel     = lock_port;
      sel_vld = pend[lock_port];
    end else if (pend == 2'b11) begin
      sel     = ~last_grant;
      sel_vld = 1'b1;
    end else if (pend[0]) begin
      sel     = PORT_I;
      sel_vld = 1'b1;
    end else if (pend[1]) begin
      sel     = PORT_D;
      sel_vld = 1'b1;
    end
    sel_slot = slot_q[sel];
  end

  // FSM next state and handshake outputs; memory fields are live on the issue cycle, held afterwards.
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    mem_req   = 1'b0;
    clr       = 2'b00;
    p_done    = 2'b00;
    p_rdata   = '0;
    case (state)
      S_IDLE: begin
        if (sel_vld && mem_ready) begin
          issue    = 1'b1;
          mem_req  = 1'b1;
          clr[sel] = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          p_done[owner] = 1'b1;
          p_rdata       = mem_rdata;
          state_nx      = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    mem_we    = issue ? sel_slot.we    : we_q;
    mem_addr  = issue ? sel_slot.addr  : addr_q;
    mem_wdata = issue ? sel_slot.wdata : wdata_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latch owner, round-robin history and the issued memory fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= PORT_I;
      last_grant <= PORT_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (issue) begin
      owner      <= sel;
      last_grant <= sel;
      we_q       <= sel_slot.we;
      addr_q     <= sel_slot.addr;
      wdata_q    <= sel_slot.wdata;
    end
  end

  // Refill lock: opened by a block-aligned read, closed by burst end, owner write or idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock      <= 1'b0;
      lock_port <= PORT_I;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (issue) begin
        if (!sel_slot.we && sel_slot.addr[OFFSET_W-1:0] == '0) begin
          lock      <= 1'b1;
          lock_port <= sel;
          burst_cnt <= '0;
        end else if (sel_slot.we && lock && sel == lock_port) begin
          lock <= 1'b0;
        end
      end else if (state == S_WAIT && mem_done && lock && owner == lock_port && !we_q) begin
        if (burst_cnt == BC_W'(BURST_LEN - 1)) lock <= 1'b0;
        burst_cnt <= burst_cnt + BC_W'(1);
      end
      if (state == S_IDLE && lock && !pend[lock_port]) begin
        if (idle_cnt == TMO_W'(LOCK_TMO - 1)) begin
          lock     <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TMO_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] grant0_q, grant1_q, conflict_q;
  logic        blocked;

  assign blocked = (state == S_IDLE) &&
                   ((lock && pend[~lock_port]) || (issue && pend == 2'b11));

  // Saturating grant and conflict statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (issue && sel == PORT_I) grant0_q <= sat_inc(grant0_q);
      if (issue && sel == PORT_D) grant1_q <= sat_inc(grant1_q);
      if (blocked)                conflict_q <= sat_inc(conflict_q);
    end
  end

  assign st_grant0   = grant0_q;
  assign st_grant1   = grant1_q;
  assign st_conflict = conflict_q;
`else
  assign st_grant0   = '0;
  assign st_grant1   = '0;
  assign st_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int LOCK_TMO  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]             p_req   = '0;
  logic [1:0]             p_we    = '0;
  logic [1:0][ADDR_W-1:0] p_addr  = '0;
  logic [1:0][DATA_W-1:0] p_wdata = '0;
  logic [1:0]             p_ready, p_done;
  logic [DATA_W-1:0]      p_rdata;
  logic                   mem_req, mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_ready = 1'b1;
  logic                   mem_done  = 1'b0;
  logic [DATA_W-1:0]      mem_rdata = '0;
  logic [15:0]            st_grant0, st_grant1, st_conflict;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ready(p_ready), .p_done(p_done), .p_rdata(p_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .st_grant0(st_grant0), .st_grant1(st_grant1), .st_conflict(st_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                cyc;
  } req_t;

  req_t exp0[$];
  req_t exp1[$];
  req_t iss_q[$];
  int   done_port[$];
  int   done_cyc[$];
  int   iss_cyc[$];
  int   req_cnt = 0;
  int   mem_cnt = 0;
  int   mem_lat = 3;
  logic [ADDR_W-1:0] mem_addr_lat = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_of(input logic [ADDR_W-1:0] a);
    if (a == 16'h0044) return 32'hCAFE0001;
    return {16'hBEEF, a};
  endfunction

  function automatic int dp(input int i);
    return (i < done_port.size()) ? done_port[i] : -1;
  endfunction
  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction
  function automatic int ic(input int i);
    return (i < iss_cyc.size()) ? iss_cyc[i] : -1;
  endfunction

  // Memory model: answers each issued request mem_lat cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    mem_done  = 1'b0;
    mem_rdata = '0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_done  = 1'b1;
        mem_rdata = rd_of(mem_addr_lat);
      end
    end
  end

  // Monitor: log issues, match completions against per-port expected queues.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_req) begin
        req_t r;
        r.we = mem_we; r.addr = mem_addr; r.wdata = mem_wdata; r.cyc = cyc;
        iss_q.push_back(r);
        req_cnt++;
        mem_addr_lat = mem_addr;
        mem_cnt = mem_lat;
      end
      if (p_done != 2'b00) begin
        int   port;
        req_t e;
        req_t r;
        port = p_done[1] ? 1 : 0;
        chk("done_onehot", 64'($onehot(p_done)), 1);
        if (iss_q.size() == 0 || (port == 0 && exp0.size() == 0) || (port == 1 && exp1.size() == 0)) begin
          chk("spurious_done", p_done, 0);
        end else begin
          r = iss_q.pop_front();
          e = (port == 0) ? exp0.pop_front() : exp1.pop_front();
          chk("issue_addr", r.addr, e.addr);
          chk("issue_we", r.we, e.we);
          if (e.we) chk("issue_wdata", r.wdata, e.wdata);
          else      chk("rdata", p_rdata, rd_of(e.addr));
          done_port.push_back(port);
          done_cyc.push_back(cyc);
          iss_cyc.push_back(r.cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    exp0.delete(); exp1.delete(); iss_q.delete();
    done_port.delete(); done_cyc.delete(); iss_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    p_req = 2'b00;
    mem_ready = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input int port, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_t e;
    e.we = we; e.addr = a; e.wdata = d; e.cyc = cyc;
    p_req[port]   = 1'b1;
    p_we[port]    = we;
    p_addr[port]  = a;
    p_wdata[port] = d;
    if (port == 0) exp0.push_back(e);
    else           exp1.push_back(e);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    p_req = 2'b00;
  endtask

  task automatic wait_ready(input int port);
    int n = 0;
    while (!p_ready[port] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || mem_cnt != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int n;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p_ready", p_ready, 2'b11);
    chk("rst_p_done", p_done, 2'b00);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stats", {st_grant0, st_grant1, st_conflict}, 0);

    // Single read on port 0
    do_reset();
    mem_lat = 3;
    @(posedge clk);
    #1;
    send(0, 1'b0, 16'h0044, '0);
    t0 = cyc;
    release_req();
    wait_drain();
    chk("t1_count", done_port.size(), 1);
    chk("t1_port", dp(0), 0);
    chk("t1_issue_latency", ic(0), t0 + 1);
    chk("t1_done_latency", dc(0), ic(0) + 3);
    chk("t1_port1_ready", p_ready[1], 1);

    // Simultaneous writes
    do_reset();
    @(posedge clk);
    #1;
    send(0, 1'b1, 16'h0010, 32'h11);
    send(1, 1'b1, 16'h0020, 32'h22);
    t0 = cyc;
    release_req();
    wait_drain();
    chk("t2_count", done_port.size(), 2);
    chk("t2_first", dp(0), 0);
    chk("t2_second", dp(1), 1);
    chk("t2_first_issue", ic(0), t0 + 1);
`ifdef ARB_STATS_EN
    chk("t2_grant0", st_grant0, 1);
    chk("t2_grant1", st_grant1, 1);
    chk("t2_conflict", (st_conflict >= 16'd1), 1);
`else
    chk("t2_stats_off", {st_grant0, st_grant1, st_conflict}, 0);
`endif

    // Refill lock: 8 port-1 reads finish before port 0
    do_reset();
    @(posedge clk);
    #1;
    send(1, 1'b0, 16'h0100, '0);
    release_req();
    send(0, 1'b0, 16'h0200, '0);
    release_req();
    for (int k = 1; k < BURST_LEN; k++) begin
      wait_ready(1);
      send(1, 1'b0, 16'(16'h0100 + 4 * k), '0);
      release_req();
    end
    wait_drain();
    chk("t3_count", done_port.size(), BURST_LEN + 1);
    for (int i = 0; i < BURST_LEN; i++) chk("t3_burst_port", dp(i), 1);
    chk("t3_last_port", dp(BURST_LEN), 0);

    // Lock timeout
    do_reset();
    @(posedge clk);
    #1;
    send(1, 1'b0, 16'h0100, '0);
    release_req();
    send(0, 1'b0, 16'h0200, '0);
    release_req();
    wait_drain();
    chk("t4_count", done_port.size(), 2);
    chk("t4_first", dp(0), 1);
    chk("t4_second", dp(1), 0);
    chk("t4_timeout_gap", ic(1) - dc(0), LOCK_TMO + 1);

    // Memory stall
    do_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    send(1, 1'b1, 16'h0300, 32'h33);
    n = req_cnt;
    release_req();
    repeat (9) @(posedge clk);
    #1;
    chk("t5_no_req_stalled", req_cnt, n);
    mem_ready = 1'b1;
    t0 = cyc;
    wait_drain();
    chk("t5_count", done_port.size(), 1);
    chk("t5_issue_on_ready", ic(0), t0);

    // Reset while waiting on memory
    do_reset();
    mem_lat = 6;
    @(posedge clk);
    #1;
    send(0, 1'b0, 16'h0080, '0);
    n = req_cnt;
    release_req();
    t0 = 0;
    while (req_cnt == n && t0 < 50) begin
      @(posedge clk);
      #1;
      t0++;
    end
    chk("t6_issued", (req_cnt > n), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    t0 = 0;
    do begin
      @(negedge clk);
      t0++;
    end while (!mem_done && t0 < 50);
    chk("t6_late_done_seen", mem_done, 1);
    chk("t6_no_p_done", p_done, 2'b00);
    chk("t6_p_ready", p_ready, 2'b11);
    chk("t6_p_rdata", p_rdata, 0);
    mem_lat = 3;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
